// File: rtl/ise_color_accum_pkg.sv
// rtl/ise_color_accum_pkg.sv - shared codes, widths, state encoding and pixel helpers for the ISE classifier
package ise_color_accum_pkg;

    localparam int PIX_PER_IMG_DEF = 16384;
    localparam int IDX_W_DEF       = 5;
    localparam int CNT_W_DEF       = 15;
    localparam int SUM_W_DEF       = 22;

    typedef enum logic [1:0] {
        COLOR_R = 2'd0,
        COLOR_G = 2'd1,
        COLOR_B = 2'd2
    } color_e;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DIV   = 2'd2,
        ST_EMIT  = 2'd3
    } state_e;

    // Ties resolve towards R, then G.
    function automatic color_e classify(input logic [23:0] p);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = p[23:16];
        g = p[15:8];
        b = p[7:0];
        if (r >= g && r >= b) return COLOR_R;
        else if (g >= b)      return COLOR_G;
        return COLOR_B;
    endfunction

    function automatic logic [7:0] chan_of(input logic [23:0] p, input color_e c);
        case (c)
            COLOR_R: return p[23:16];
            COLOR_G: return p[15:8];
            default: return p[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ise_color_accum_div.sv
// rtl/ise_color_accum_div.sv - restoring divider, one quotient bit per cycle, done after SUM_W cycles
module ise_color_accum_div #(
    parameter int SUM_W = 22,
    parameter int CNT_W = 15,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [OUT_W-1:0] quotient
);
    localparam int BW = $clog2(SUM_W + 1);

    logic [SUM_W-1:0] quo;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] dvs;
    logic [BW-1:0]    bits_left;
    logic             busy;
    logic [CNT_W:0]   shifted;
    logic             fits;

    // Dividend bits shift out of quo's MSB while quotient bits shift into its LSB.
    assign shifted  = {rem, quo[SUM_W-1]};
    assign fits     = (shifted >= {1'b0, dvs});
    assign quotient = quo[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo       <= dividend;
                rem       <= '0;
                dvs       <= divisor;
                bits_left <= BW'(SUM_W);
                busy      <= 1'b1;
            end else if (busy) begin
                rem       <= fits ? (shifted[CNT_W-1:0] - dvs) : shifted[CNT_W-1:0];
                quo       <= {quo[SUM_W-2:0], fits};
                bits_left <= bits_left - BW'(1);
                if (bits_left == BW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ise_color_accum.sv
// rtl/ise_color_accum.sv - per-image dominant colour classifier emitting one record per image
module ise_color_accum
    import ise_color_accum_pkg::*;
#(
    parameter int PIX_PER_IMG = PIX_PER_IMG_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SUM_W       = SUM_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [IDX_W-1:0] image_in_index,
    input  logic [23:0]      pixel_in,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [1:0]       rec_color,
    output logic [IDX_W-1:0] rec_index,
    output logic [7:0]       rec_avg,
    output logic [CNT_W-1:0] rec_count,
    output logic             idx_err
);
    state_e           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] cnt [3];
    logic [SUM_W-1:0] sum [3];
    color_e           pix_cls;
    color_e           win;
    logic [7:0]       pix_chan;
    logic [CNT_W-1:0] win_cnt;
    logic [SUM_W-1:0] win_sum;
    logic             div_done;
    logic [7:0]       div_quo;
    logic             accept;
    logic             last_pix;

    assign pix_ready = (state == ST_ACCUM);
    assign accept    = pix_valid & pix_ready;
    assign last_pix  = (pix_cnt == CNT_W'(PIX_PER_IMG - 1));
    assign pix_cls   = classify(pixel_in);
    assign pix_chan  = chan_of(pixel_in, pix_cls);

    // Argmax over class counts with the same R>G>B tie priority as pixels.
    always_comb begin
        win = COLOR_B;
        if (cnt[0] >= cnt[1] && cnt[0] >= cnt[2]) win = COLOR_R;
        else if (cnt[1] >= cnt[2])                win = COLOR_G;
        win_cnt = cnt[2];
        win_sum = sum[2];
        case (win)
            COLOR_R: begin win_cnt = cnt[0]; win_sum = sum[0]; end
            COLOR_G: begin win_cnt = cnt[1]; win_sum = sum[1]; end
            default: ;
        endcase
    end

    ise_color_accum_div #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W),
        .OUT_W (8)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (state == ST_LOAD),
        .dividend (win_sum),
        .divisor  (win_cnt),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_ACCUM;
            pix_cnt   <= '0;
            for (int c = 0; c < 3; c++) begin
                cnt[c] <= '0;
                sum[c] <= '0;
            end
            rec_valid <= 1'b0;
            rec_color <= 2'd0;
            rec_index <= '0;
            rec_avg   <= '0;
            rec_count <= '0;
            idx_err   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: if (accept) begin
                    if (pix_cnt == '0)                   rec_index <= image_in_index;
                    else if (image_in_index != rec_index) idx_err   <= 1'b1;
                    for (int c = 0; c < 3; c++) begin
                        if (int'(pix_cls) == c) begin
                            cnt[c] <= cnt[c] + CNT_W'(1);
                            sum[c] <= sum[c] + SUM_W'(pix_chan);
                        end
                    end
                    if (last_pix) begin
                        pix_cnt <= '0;
                        state   <= ST_LOAD;
                    end else begin
                        pix_cnt <= pix_cnt + CNT_W'(1);
                    end
                end
                ST_LOAD: begin
                    rec_color <= win;
                    rec_count <= win_cnt;
                    state     <= ST_DIV;
                end
                ST_DIV: if (div_done) begin
                    rec_avg   <= div_quo;
                    rec_valid <= 1'b1;
                    state     <= ST_EMIT;
                end
                ST_EMIT: if (rec_ready) begin
                    rec_valid <= 1'b0;
                    pix_cnt   <= '0;
                    for (int c = 0; c < 3; c++) begin
                        cnt[c] <= '0;
                        sum[c] <= '0;
                    end
                    state <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_ise_color_accum.sv
// tb/tb_ise_color_accum.sv - randomized self-checking bench for ise_color_accum with a reference model
module tb_ise_color_accum;
    localparam int P  = 64;
    localparam int IW = 5;
    localparam int CW = 7;
    localparam int SW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [IW-1:0] image_in_index = '0;
    logic [23:0]   pixel_in = '0;
    logic          rec_valid;
    logic          rec_ready = 1'b1;
    logic [1:0]    rec_color;
    logic [IW-1:0] rec_index;
    logic [7:0]    rec_avg;
    logic [CW-1:0] rec_count;
    logic          idx_err;

    ise_color_accum #(
        .PIX_PER_IMG (P),
        .IDX_W       (IW),
        .CNT_W       (CW),
        .SUM_W       (SW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .image_in_index (image_in_index),
        .pixel_in       (pixel_in),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_color      (rec_color),
        .rec_index      (rec_index),
        .rec_avg        (rec_avg),
        .rec_count      (rec_count),
        .idx_err        (idx_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [23:0]   img  [P];
    logic [IW-1:0] idxs [P];
    logic          exp_err = 1'b0;
    logic [7:0]    levels [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: each pixel votes for the first strictly-largest channel; the class with
    // the first strictly-largest vote count wins; mean is plain integer division.
    task automatic model(output int col, output int avg, output int cnt);
        int c [3];
        int s [3];
        int ch [3];
        int best;
        for (int k = 0; k < 3; k++) begin c[k] = 0; s[k] = 0; end
        for (int i = 0; i < P; i++) begin
            ch[0] = int'(img[i][23:16]);
            ch[1] = int'(img[i][15:8]);
            ch[2] = int'(img[i][7:0]);
            best = 0;
            for (int k = 1; k < 3; k++) if (ch[k] > ch[best]) best = k;
            c[best] += 1;
            s[best] += ch[best];
            if (i > 0 && idxs[i] != idxs[0]) exp_err = 1'b1;
        end
        col = 0;
        for (int k = 1; k < 3; k++) if (c[k] > c[col]) col = k;
        cnt = c[col];
        avg = s[col] / c[col];
    endtask

    task automatic fill(input logic [23:0] a, input int na, input logic [23:0] b, input logic [IW-1:0] idx);
        for (int i = 0; i < P; i++) begin
            img[i]  = (i < na) ? a : b;
            idxs[i] = idx;
        end
    endtask

    task automatic fill_rand(input logic [IW-1:0] idx);
        for (int i = 0; i < P; i++) begin
            if ($urandom_range(0, 1) == 0)
                img[i] = {levels[$urandom_range(0, 3)], levels[$urandom_range(0, 3)], levels[$urandom_range(0, 3)]};
            else
                img[i] = 24'($urandom);
            idxs[i] = idx;
        end
    endtask

    task automatic run_image(input string tag, input int bp);
        int col, avg, cnt, lat, unready;
        logic [31:0] snap;
        model(col, avg, cnt);
        rec_ready = (bp == 0);
        unready = 0;
        for (int i = 0; i < P; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                @(posedge clk); #1;
            end
            pix_valid      = 1'b1;
            pixel_in       = img[i];
            image_in_index = idxs[i];
            if (!pix_ready) unready++;
            @(posedge clk); #1;
        end
        check({tag, "_ready_accum"}, unready, 0);
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            pix_valid = $urandom_range(0, 1) == 1;
            pixel_in  = 24'($urandom);
            @(posedge clk); #1;
            if (pix_ready) unready++;
            if (rec_valid) begin lat = k; break; end
        end
        pix_valid = 1'b0;
        check({tag, "_latency"}, lat, SW + 2);
        check({tag, "_busy"}, unready, 0);
        check({tag, "_color"}, rec_color, col);
        check({tag, "_avg"}, rec_avg, avg);
        check({tag, "_count"}, rec_count, cnt);
        check({tag, "_index"}, rec_index, idxs[0]);
        check({tag, "_idx_err"}, idx_err, exp_err);
        snap = {13'd0, rec_color, rec_index, rec_avg, rec_count};
        for (int k = 0; k < bp; k++) begin
            pix_valid = 1'b1;
            pixel_in  = 24'($urandom);
            @(posedge clk); #1;
            check({tag, "_bp_hold"}, {13'd0, rec_color, rec_index, rec_avg, rec_count}, snap);
            check({tag, "_bp_valid"}, {pix_ready, rec_valid}, 2'b01);
        end
        pix_valid = 1'b0;
        rec_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_after_hs"}, {pix_ready, rec_valid}, 2'b10);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rst_flags"}, {pix_ready, rec_valid, idx_err}, 3'b100);
        check({tag, "_rst_rec"}, {rec_color, rec_index, rec_avg, rec_count}, 0);
    endtask

    initial begin
        levels[0] = 8'h00; levels[1] = 8'h40; levels[2] = 8'h80; levels[3] = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("init");
        reset = 1'b1;

        fill(24'hFF0000, P, 24'hFF0000, 5'd7);
        run_image("red", 0);
        fill(24'h808080, P, 24'h808080, 5'd1);
        run_image("grey", 0);
        fill(24'h00C800, P / 2, 24'h000064, 5'd3);
        run_image("gtie", 0);
        fill(24'h0000F0, 39, 24'h300000, 5'd5);
        run_image("mixed", 0);
        fill_rand(5'd11);
        run_image("bp", 20);
        for (int n = 0; n < 3; n++) begin
            fill_rand(5'($urandom_range(0, 31)));
            run_image("rand", $urandom_range(0, 3));
        end

        fill_rand(5'd2);
        idxs[30] = 5'd9;
        run_image("glitch", 0);
        fill_rand(5'd6);
        run_image("sticky", 0);

        fill_rand(5'd3);
        for (int i = 0; i < 20; i++) begin
            pix_valid      = 1'b1;
            pixel_in       = img[i];
            image_in_index = idxs[i];
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("midimg");
        reset = 1'b1;
        exp_err = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("no_partial_rec", rec_valid, 1'b0);
        fill(24'h0000FF, P, 24'h0000FF, 5'd4);
        run_image("blue", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
